load_store_unit: RTL and testbench

- Sits directly upstream of the word-addressed data memory; all datapath loads and stores pass through it.
- Converts byte-addressed load/store requests (byte, halfword, word; signed or unsigned) into word-wide memory accesses.
- Sub-word stores are done as read-modify-write.
- Load data is extracted and extended before it is returned to the datapath.

---
 rtl/load_store_unit.sv | 193 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: byte-addressed load/store front end for a word-addressed
// data memory. Byte and halfword stores use read-modify-write. Load results
// are lane-extracted and zero/sign-extended before they reach the datapath.
//
// Optional build macro: MISALIGN_TRAP_EN
//   Defined   - a misaligned half or word access completes without a memory
//               access and pulses Misaligned_o together with Done_o.
//   Undefined - misaligned low address bits are ignored; Misaligned_o stays 0.
//
// Handshake: Req_Valid_i is sampled only on an edge where Busy_o=0. There is
// no ready signal. A request presented while Busy_o=1 is dropped, so the
// issuer must hold or re-present it. Done_o is a one-cycle pulse raised while
// the unit is back in IDLE. A new request may therefore be accepted in the
// same cycle that Done_o is high.
module load_store_unit #(
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = 32'h1001_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Req_Valid_i,
    input  logic                  Req_Write_i,
    input  logic [1:0]            Size_i,
    input  logic                  Signed_i,
    input  logic [DATA_WIDTH-1:0] Address_i,
    input  logic [DATA_WIDTH-1:0] Write_Data_i,
    output logic                  Busy_o,
    output logic                  Done_o,
    output logic [DATA_WIDTH-1:0] Read_Data_o,
    output logic                  Misaligned_o,
    output logic                  Mem_Write_Enable_o,
    output logic [DATA_WIDTH-1:0] Mem_Address_o,
    output logic [DATA_WIDTH-1:0] Mem_Write_Data_o,
    input  logic [DATA_WIDTH-1:0] Mem_Read_Data_i,
    output logic [1:0]            Debug_State_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD     = 2'd1,
        RMW_READ = 2'd2,
        WRITE    = 2'd3
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;

    state_t                  state_q;
    state_t                  state_d;

    // Request fields latched at acceptance
    logic                    wr_q;
    logic [1:0]              size_q;
    logic                    sgn_q;
    logic [DATA_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   data_q;

    // Registered result/status outputs
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    done_q;
    logic                    mis_q;

    // Decode of the incoming request in IDLE
    logic                    accept;
    logic                    trap;
    logic                    misaligned_req;

    // Lane handling on the memory read word
    logic [7:0]              ld_byte;
    logic [15:0]             ld_half;
    logic [DATA_WIDTH-1:0]   ld_ext;
    logic [DATA_WIDTH-1:0]   merged;

    // Misalignment detection on the raw request; constant 0 without the trap
    always_comb begin
        misaligned_req = 1'b0;
`ifdef MISALIGN_TRAP_EN
        if (Size_i == SIZE_HALF) begin
            misaligned_req = Address_i[0];
        end else if (Size_i[1]) begin
            misaligned_req = (Address_i[1:0] != 2'b00);
        end
`endif
    end

    // State register; reset aborts any operation in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and request acceptance
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        trap    = 1'b0;
        case (state_q)
            IDLE: begin
                if (Req_Valid_i) begin
                    if (misaligned_req) begin
                        // Completes from IDLE with no memory access
                        trap = 1'b1;
                    end else begin
                        accept = 1'b1;
                        if (!Req_Write_i) begin
                            state_d = LOAD;
                        end else if (Size_i[1]) begin
                            state_d = WRITE;
                        end else begin
                            state_d = RMW_READ;
                        end
                    end
                end
            end
            LOAD:     state_d = IDLE;
            RMW_READ: state_d = WRITE;
            WRITE:    state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Extract and extend the addressed lane of the memory word (little-endian)
    always_comb begin
        ld_byte = Mem_Read_Data_i[{addr_q[1:0], 3'b000} +: 8];
        ld_half = addr_q[1] ? Mem_Read_Data_i[31:16] : Mem_Read_Data_i[15:0];
        case (size_q)
            SIZE_BYTE: ld_ext = {{24{sgn_q & ld_byte[7]}}, ld_byte};
            SIZE_HALF: ld_ext = {{16{sgn_q & ld_half[15]}}, ld_half};
            default:   ld_ext = Mem_Read_Data_i;
        endcase
    end

    // Merge the low byte/half of the store data into the word just read
    always_comb begin
        merged = Mem_Read_Data_i;
        case (size_q)
            SIZE_BYTE: merged[{addr_q[1:0], 3'b000} +: 8] = data_q[7:0];
            SIZE_HALF: begin
                if (addr_q[1]) begin
                    merged[31:16] = data_q[15:0];
                end else begin
                    merged[15:0] = data_q[15:0];
                end
            end
            default:   merged = data_q;
        endcase
    end

    // Request latch, load result, merged store word and completion pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q    <= 1'b0;
            size_q  <= 2'b00;
            sgn_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            done_q <= (state_q == LOAD) || (state_q == WRITE) || trap;
            mis_q  <= trap;
            if (accept) begin
                wr_q   <= Req_Write_i;
                size_q <= Size_i;
                sgn_q  <= Signed_i;
                addr_q <= Address_i;
                data_q <= Write_Data_i;
            end
            if (state_q == LOAD) begin
                rdata_q <= ld_ext;
            end
            if (state_q == RMW_READ) begin
                data_q <= merged;
            end
        end
    end

    // Memory side is only driven while an access is in progress, so every
    // output reads 0 in IDLE and straight out of reset.
    assign Busy_o             = (state_q != IDLE);
    assign Done_o             = done_q;
    assign Read_Data_o        = rdata_q;
    assign Misaligned_o       = mis_q;
    assign Mem_Write_Enable_o = (state_q == WRITE) && wr_q;
    assign Mem_Address_o      = Busy_o ? ((addr_q - BASE_ADDRESS) >> 2) : '0;
    assign Mem_Write_Data_o   = (state_q == WRITE) ? data_q : '0;
    assign Debug_State_o      = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized checks of load_store_unit
// against a byte-array reference model of the data memory.
module tb_load_store_unit;

    localparam logic [31:0] BASE = 32'h1001_0000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic        busy;
    logic        done;
    logic [31:0] rd;
    logic        misaligned;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [1:0]  dbg_state;

    load_store_unit dut (
        .clk                (clk),
        .reset              (reset),
        .Req_Valid_i        (req_valid),
        .Req_Write_i        (req_write),
        .Size_i             (req_size),
        .Signed_i           (req_signed),
        .Address_i          (req_addr),
        .Write_Data_i       (req_data),
        .Busy_o             (busy),
        .Done_o             (done),
        .Read_Data_o        (rd),
        .Misaligned_o       (misaligned),
        .Mem_Write_Enable_o (mem_we),
        .Mem_Address_o      (mem_addr),
        .Mem_Write_Data_o   (mem_wdata),
        .Mem_Read_Data_i    (mem_rdata),
        .Debug_State_o      (dbg_state)
    );

    // ---------------- environment memory (16 words) ----------------
    logic [31:0] env_mem [0:15];
    logic        mem_fill;

    function automatic logic [31:0] init_word(input int i);
        return 32'h1357_9BDF ^ (32'(i) * 32'h0101_0101);
    endfunction

    always @(posedge clk) begin
        if (mem_fill) begin
            for (int i = 0; i < 16; i++) env_mem[i] <= init_word(i);
        end else if (mem_we) begin
            env_mem[mem_addr[3:0]] <= mem_wdata;
        end
    end
    assign mem_rdata = env_mem[mem_addr[3:0]];

    // ---------------- reference model (byte array) ----------------
    logic [7:0]  ref_bytes [0:63];
    logic [31:0] exp_q [$];
    logic [31:0] exp_rd;
    int tests_run    = 0;
    int tests_failed = 0;

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic is_mis(input logic [1:0] sz, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
        return ((sz == 2'b01) && a[0]) || ((sz >= 2'b10) && (a[1:0] != 2'b00));
`else
        return 1'b0;
`endif
    endfunction

    function automatic int ref_off(input logic [1:0] sz, input logic [31:0] a);
        int off;
        off = int'((a - BASE) & 32'h3F);
        return off & ~(nbytes(sz) - 1);
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sg,
                                             input logic [31:0] a);
        int n, off;
        logic [31:0] v, mask;
        n = nbytes(sz);
        off = ref_off(sz, a);
        v = 0;
        for (int k = 0; k < n; k++) v = v | (32'(ref_bytes[off + k]) << (8 * k));
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
        if (sg && n < 4 && v[8 * n - 1]) v = v | ~mask;
        return v;
    endfunction

    task automatic ref_store(input logic [1:0] sz, input logic [31:0] a,
                             input logic [31:0] d);
        int n, off;
        logic [31:0] t;
        n = nbytes(sz);
        off = ref_off(sz, a);
        for (int k = 0; k < n; k++) begin
            t = d >> (8 * k);
            ref_bytes[off + k] = t[7:0];
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        return ref_load(2'b10, 1'b0, a);
    endfunction

    // ---------------- driver ----------------
    // Presents one request, then reports cycles to Done_o (0 = timeout),
    // write strobes seen, the last written address/data and Misaligned_o.
    task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] d,
                         output int lat, output int wc, output logic [31:0] waddr,
                         output logic [31:0] wdata, output logic mis);
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_size = sz;
        req_signed = sg; req_addr = a; req_data = d;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0; wc = 0; waddr = 0; wdata = 0; mis = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (mem_we) begin wc++; waddr = mem_addr; wdata = mem_wdata; end
            if (done) begin lat = c; mis = misaligned; break; end
            @(posedge clk); #1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        reset = 1'b1; mem_fill = 1'b1; req_valid = 1'b0; req_write = 1'b0;
        req_size = 2'b00; req_signed = 1'b0; req_addr = 0; req_data = 0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({busy, done, misaligned, mem_we} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_flags: busy/done/mis/we=%b expected 0000",
                     {busy, done, misaligned, mem_we});
        end
        tests_run++;
        if (rd !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_data: rd=%h maddr=%h mwdata=%h expected 0", rd, mem_addr,
                     mem_wdata);
        end
        @(negedge clk);
        reset = 1'b0; mem_fill = 1'b0;
        exp_rd = 32'h0;
    endtask

    task automatic test_word_store_load;
        int lat, wc; logic [31:0] wa, wd; logic mis;
        issue(1'b1, 2'b10, 1'b0, BASE + 32'd8, 32'hDEAD_BEEF, lat, wc, wa, wd, mis);
        ref_store(2'b10, BASE + 32'd8, 32'hDEAD_BEEF);
        tests_run++;
        if (lat !== 2 || wc !== 1 || wa !== 32'd2 || wd !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL word_store: lat=%0d wc=%0d addr=%h data=%h expected 2 1 2 deadbeef",
                     lat, wc, wa, wd);
        end
        issue(1'b0, 2'b10, 1'b0, BASE + 32'd8, 32'h0, lat, wc, wa, wd, mis);
        exp_rd = 32'hDEAD_BEEF;
        tests_run++;
        if (lat !== 2 || wc !== 0 || rd !== exp_rd) begin
            tests_failed++;
            $display("FAIL word_load: lat=%0d wc=%0d rd=%h expected 2 0 %h", lat, wc, rd, exp_rd);
        end
    endtask

    task automatic test_byte_store;
        int lat, wc; logic [31:0] wa, wd; logic mis;
        issue(1'b1, 2'b00, 1'b0, BASE + 32'd9, 32'h0000_005A, lat, wc, wa, wd, mis);
        ref_store(2'b00, BASE + 32'd9, 32'h0000_005A);
        tests_run++;
        if (lat !== 3 || wc !== 1 || wa !== 32'd2 || wd !== 32'hDEAD_5AEF) begin
            tests_failed++;
            $display("FAIL byte_store: lat=%0d wc=%0d addr=%h data=%h expected 3 1 2 dead5aef",
                     lat, wc, wa, wd);
        end
        @(negedge clk);
        tests_run++;
        if (env_mem[2] !== 32'hDEAD_5AEF) begin
            tests_failed++;
            $display("FAIL byte_store_mem: word2=%h expected dead5aef", env_mem[2]);
        end
    endtask

    task automatic test_signed_loads;
        int lat, wc; logic [31:0] wa, wd; logic mis;
        logic [31:0] offs [4] = '{32'd1, 32'd3, 32'd2, 32'd2};
        logic [1:0]  szs  [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
        logic        sgs  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [31:0] exps [4] = '{32'h0000_007F, 32'hFFFF_FF80, 32'h0000_80FF, 32'hFFFF_80FF};
        issue(1'b1, 2'b10, 1'b0, BASE, 32'h80FF_7F01, lat, wc, wa, wd, mis);
        ref_store(2'b10, BASE, 32'h80FF_7F01);
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, szs[i], sgs[i], BASE + offs[i], 32'h0, lat, wc, wa, wd, mis);
            exp_rd = exps[i];
            tests_run++;
            if (lat !== 2 || wc !== 0 || rd !== exp_rd) begin
                tests_failed++;
                $display("FAIL sub_load_%0d: lat=%0d wc=%0d rd=%h expected 2 0 %h",
                         i, lat, wc, rd, exp_rd);
            end
        end
    endtask

    task automatic test_busy_reject;
        logic [31:0] a, exp;
        int wc, dones;
        a = BASE + 32'd12;
        exp = ref_word(a);
        wc = 0; dones = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0;
        req_addr = a; req_data = 32'h0;
        @(posedge clk); #1;
        // LOAD in progress: present a store that must be dropped
        req_write = 1'b1; req_data = 32'h1234_5678;
        if (mem_we) wc++;
        if (done) dones++;
        @(posedge clk); #1;
        tests_run++;
        if (done !== 1'b1 || busy !== 1'b0 || dones !== 0 || rd !== exp) begin
            tests_failed++;
            $display("FAIL busy_first_done: done=%b busy=%b early=%0d rd=%h expected 1 0 0 %h",
                     done, busy, dones, rd, exp);
        end
        // Done cycle: a load presented now is accepted on this edge
        req_write = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (mem_we) wc++;
        tests_run++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL busy_b2b_accept: busy=%b done=%b expected 1 0", busy, done);
        end
        @(posedge clk); #1;
        exp_rd = exp;
        tests_run++;
        if (done !== 1'b1 || wc !== 0 || rd !== exp_rd) begin
            tests_failed++;
            $display("FAIL busy_reject: done=%b wc=%0d rd=%h expected 1 0 %h", done, wc, rd, exp_rd);
        end
    endtask

    task automatic test_misalign;
        int lat, wc; logic [31:0] wa, wd; logic mis;
        issue(1'b0, 2'b10, 1'b0, BASE + 32'd2, 32'h0, lat, wc, wa, wd, mis);
`ifdef MISALIGN_TRAP_EN
        tests_run++;
        if (lat !== 1 || mis !== 1'b1 || wc !== 0 || rd !== exp_rd) begin
            tests_failed++;
            $display("FAIL misalign_trap: lat=%0d mis=%b wc=%0d rd=%h expected 1 1 0 %h",
                     lat, mis, wc, rd, exp_rd);
        end
`else
        exp_rd = 32'h80FF_7F01;
        tests_run++;
        if (lat !== 2 || mis !== 1'b0 || wc !== 0 || rd !== exp_rd) begin
            tests_failed++;
            $display("FAIL misalign_ignore: lat=%0d mis=%b wc=%0d rd=%h expected 2 0 0 %h",
                     lat, mis, wc, rd, exp_rd);
        end
`endif
    endtask

    task automatic test_reset_mid_rmw;
        int wc;
        wc = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = BASE + 32'd5; req_data = 32'h0000_00C3;
        @(posedge clk); #1;
        req_valid = 1'b0;
        tests_run++;
        if (busy !== 1'b1 || mem_we !== 1'b0) begin
            tests_failed++;
            $display("FAIL rmw_started: busy=%b we=%b expected 1 0", busy, mem_we);
        end
        #1 reset = 1'b1;
        #1;
        tests_run++;
        if ({busy, done, misaligned, mem_we} !== 4'b0000 || rd !== 32'h0 ||
            mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_mid_rmw: flags=%b rd=%h maddr=%h mwdata=%h expected 0",
                     {busy, done, misaligned, mem_we}, rd, mem_addr, mem_wdata);
        end
        repeat (2) begin @(posedge clk); #1; if (mem_we) wc++; end
        @(negedge clk);
        reset = 1'b0;
        exp_rd = 32'h0;
        repeat (3) begin @(posedge clk); #1; if (mem_we) wc++; end
        tests_run++;
        if (wc !== 0 || busy !== 1'b0 || env_mem[1] !== ref_word(BASE + 32'd4)) begin
            tests_failed++;
            $display("FAIL reset_no_write: wc=%0d busy=%b word1=%h expected 0 0 %h",
                     wc, busy, env_mem[1], ref_word(BASE + 32'd4));
        end
    endtask

    task automatic test_random;
        int lat, wc, exp_lat, exp_wc;
        logic [31:0] wa, wd, a, d, got;
        logic mis, wr, sg, exp_mis;
        logic [1:0] sz;
        for (int i = 0; i < 60; i++) begin
            wr = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            sg = 1'($urandom_range(0, 1));
            a  = BASE + 32'($urandom_range(0, 63));
            d  = $urandom;
            exp_mis = is_mis(sz, a);
            exp_lat = exp_mis ? 1 : (wr && sz < 2'b10) ? 3 : 2;
            exp_wc  = (wr && !exp_mis) ? 1 : 0;
            if (!wr && !exp_mis) exp_q.push_back(ref_load(sz, sg, a));
            if (wr && !exp_mis) ref_store(sz, a, d);
            issue(wr, sz, sg, a, d, lat, wc, wa, wd, mis);
            tests_run++;
            if (lat !== exp_lat || wc !== exp_wc || mis !== exp_mis) begin
                tests_failed++;
                $display("FAIL rand_%0d_timing: lat=%0d wc=%0d mis=%b expected %0d %0d %b",
                         i, lat, wc, mis, exp_lat, exp_wc, exp_mis);
            end
            if (exp_wc == 1) begin
                tests_run++;
                if (wa !== ((a - BASE) >> 2) || wd !== ref_word(a)) begin
                    tests_failed++;
                    $display("FAIL rand_%0d_write: addr=%h data=%h expected %h %h",
                             i, wa, wd, (a - BASE) >> 2, ref_word(a));
                end
            end
            if (!wr && !exp_mis) begin
                got = exp_q.pop_front();
                exp_rd = got;
            end
            tests_run++;
            if (rd !== exp_rd) begin
                tests_failed++;
                $display("FAIL rand_%0d_rdata: rd=%h expected %h", i, rd, exp_rd);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < 4; k++) begin
                logic [31:0] w;
                w = init_word(i) >> (8 * k);
                ref_bytes[4 * i + k] = w[7:0];
            end
        end
        test_reset();
        test_word_store_load();
        test_byte_store();
        test_signed_loads();
        test_busy_reject();
        test_misalign();
        test_reset_mid_rmw();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
